// File: rtl/motion_best_match_if.sv
// Bus between the motion-search datapath and the best-match collector.
// The master drives search control and PE results; the slave returns the winner.
interface motion_best_match_if #(
  parameter int NPE    = 16,
  parameter int DIST_W = 8
);
  logic                    start;
  logic                    CompStart;
  logic [NPE-1:0]          PEready;
  logic [NPE*DIST_W-1:0]   PEdist;
  logic [3:0]              VectorX;
  logic [3:0]              VectorY;
  logic [DIST_W-1:0]       BestDist;
  logic [3:0]              MotionX;
  logic [3:0]              MotionY;
  logic [8:0]              CandCount;
  logic                    done;
  logic                    err;

  modport master (
    output start, CompStart, PEready, PEdist, VectorX, VectorY,
    input  BestDist, MotionX, MotionY, CandCount, done, err
  );

  modport slave (
    input  start, CompStart, PEready, PEdist, VectorX, VectorY,
    output BestDist, MotionX, MotionY, CandCount, done, err
  );
endinterface

// File: rtl/motion_best_match.sv
// Best-match collector: tracks the minimum PE distance and its motion vector
// over one full search of NCAND candidates.
//
// state | meaning
// IDLE  | outputs at reset values, waiting for start
// RUN   | accepting one-hot PE strobes, tracking the minimum
// DONE  | all candidates seen, outputs frozen
module motion_best_match #(
  parameter int NPE    = 16,
  parameter int DIST_W = 8,
  parameter int NCAND  = 256
) (
  input logic clock,
  input logic reset,
  motion_best_match_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [8:0] LP_LAST = 9'(NCAND - 1);

  logic [1:0]        r_state;
  logic [DIST_W-1:0] r_best;
  logic [3:0]        r_mx;
  logic [3:0]        r_my;
  logic [8:0]        r_count;
  logic              r_done;
  logic              r_err;

  logic [DIST_W-1:0] w_sel;
  logic              w_any;
  logic              w_multi;
  logic              w_window;
  logic              w_accept;

  // One-hot AND-OR mux; only meaningful when exactly one bit is set.
  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NPE; i++) begin
      w_sel = w_sel | (bus.PEdist[i*DIST_W +: DIST_W] & {DIST_W{bus.PEready[i]}});
    end
  end

  assign w_any    = |bus.PEready;
  assign w_multi  = |(bus.PEready & (bus.PEready - NPE'(1)));
  assign w_window = (r_state == S_RUN) && bus.CompStart;
  assign w_accept = w_window && w_any && !w_multi && (r_count != 9'(NCAND));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_best  <= '1;
      r_mx    <= '0;
      r_my    <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else if (!bus.start) begin
      // Dropping start aborts the search and wins over any strobe this cycle.
      r_state <= S_IDLE;
      r_best  <= '1;
      r_mx    <= '0;
      r_my    <= '0;
      r_count <= '0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= S_RUN;
        S_RUN: begin
          if (w_window && w_multi) r_err <= 1'b1;
          if (w_accept) begin
            r_count <= r_count + 9'd1;
            if (w_sel < r_best) begin
              r_best <= w_sel;
              r_mx   <= bus.VectorX;
              r_my   <= bus.VectorY;
            end
            if (r_count == LP_LAST) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end
          end
        end
        S_DONE:  r_state <= S_DONE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.BestDist  = r_best;
  assign bus.MotionX   = r_mx;
  assign bus.MotionY   = r_my;
  assign bus.CandCount = r_count;
  assign bus.done      = r_done;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_motion_best_match.sv
// Directed bench for motion_best_match: sweeps, ties, multi-hot, abort,
// async reset and compare-window gating, with hand-computed expectations.
module tb_motion_best_match;
  logic clk = 1'b0;
  logic rst;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  motion_best_match_if #(.NPE(16), .DIST_W(8)) ifc ();

  motion_best_match #(.NPE(16), .DIST_W(8), .NCAND(256)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (ifc)
  );

  function automatic logic [3:0] vx(input int k);
    return 4'(k) ^ 4'h8;
  endfunction

  function automatic logic [3:0] vy(input int k);
    return 4'(k >> 4) ^ 4'h8;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_all(input string tag, input logic [7:0] best, input logic [3:0] mx,
                         input logic [3:0] my, input logic [8:0] cnt, input logic dn,
                         input logic er);
    chk({tag, "_best"}, 32'(ifc.BestDist), 32'(best));
    chk({tag, "_mx"},   32'(ifc.MotionX),  32'(mx));
    chk({tag, "_my"},   32'(ifc.MotionY),  32'(my));
    chk({tag, "_cnt"},  32'(ifc.CandCount), 32'(cnt));
    chk({tag, "_done"}, 32'(ifc.done),     32'(dn));
    chk({tag, "_err"},  32'(ifc.err),      32'(er));
  endtask

  // Drive one cycle of strobe data; the selected PE gets d, others get ~d.
  task automatic apply(input int k, input logic [7:0] d, input logic [15:0] rdy, input logic cs);
    ifc.PEready   = rdy;
    ifc.CompStart = cs;
    for (int i = 0; i < 16; i++) ifc.PEdist[i*8 +: 8] = (i == k % 16) ? d : ~d;
    ifc.VectorX = vx(k);
    ifc.VectorY = vy(k);
    @(posedge clk);
    #1;
    ifc.PEready = '0;
  endtask

  task automatic strobe(input int k, input logic [7:0] d);
    apply(k, d, 16'h0001 << (k % 16), 1'b1);
  endtask

  task automatic restart();
    ifc.start = 1'b0;
    apply(0, 8'h00, 16'h0000, 1'b0);
    ifc.start = 1'b1;
    apply(0, 8'h00, 16'h0000, 1'b0);
  endtask

  initial begin
    rst           = 1'b1;
    ifc.start     = 1'b0;
    ifc.CompStart = 1'b0;
    ifc.PEready   = '0;
    ifc.PEdist    = '0;
    ifc.VectorX   = '0;
    ifc.VectorY   = '0;
    #12;
    chk_all("reset", 8'hFF, 4'h0, 4'h0, 9'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // start rising with a strobe in the same cycle: strobe ignored
    ifc.start = 1'b1;
    apply(0, 8'h00, 16'h0001, 1'b1);
    chk("start_strobe_cnt", 32'(ifc.CandCount), 32'd0);
    chk("start_strobe_best", 32'(ifc.BestDist), 32'hFF);

    // full sweep, distance = index ^ 0x5A
    for (int k = 0; k < 255; k++) strobe(k, 8'(k) ^ 8'h5A);
    chk("sweep_pre_done", 32'(ifc.done), 32'd0);
    chk("sweep_pre_cnt", 32'(ifc.CandCount), 32'd255);
    strobe(255, 8'hFF ^ 8'h5A);
    chk_all("sweep", 8'h00, 4'h2, 4'hD, 9'd256, 1'b1, 1'b0);
    strobe(1, 8'h00);
    chk_all("done_hold", 8'h00, 4'h2, 4'hD, 9'd256, 1'b1, 1'b0);

    // start dropped from DONE along with a strobe: clear wins
    ifc.start = 1'b0;
    strobe(5, 8'h00);
    chk_all("clear_done", 8'hFF, 4'h0, 4'h0, 9'd0, 1'b0, 1'b0);

    // tie: candidates 10 and 200 both 3, earlier retained
    ifc.start = 1'b1;
    apply(0, 8'h00, 16'h0000, 1'b0);
    for (int k = 0; k < 256; k++) strobe(k, (k == 10 || k == 200) ? 8'h03 : 8'h40);
    chk_all("tie", 8'h03, 4'h2, 4'h8, 9'd256, 1'b1, 1'b0);

    // multi-hot replaces the zero-distance strobe; one idle all-zero cycle too
    restart();
    for (int k = 0; k < 256; k++) begin
      if (k == 8'h30) apply(k, 8'h00, 16'h0000, 1'b1);
      if (k == 8'h5A) apply(k, 8'h00, 16'h0003, 1'b1);
      else strobe(k, 8'(k) ^ 8'h5A);
    end
    chk_all("multi", 8'h01, 4'h3, 4'hD, 9'd255, 1'b0, 1'b1);
    strobe(8'h5A, 8'h00);
    chk_all("multi_last", 8'h00, 4'h2, 4'hD, 9'd256, 1'b1, 1'b1);

    // abort after 100 strobes, then a clean re-run
    restart();
    for (int k = 0; k < 100; k++) strobe(k, 8'(k) ^ 8'h5A);
    chk("abort_pre_cnt", 32'(ifc.CandCount), 32'd100);
    chk("abort_pre_best", 32'(ifc.BestDist), 32'h00);
    ifc.start = 1'b0;
    strobe(100, 8'h00);
    chk_all("abort", 8'hFF, 4'h0, 4'h0, 9'd0, 1'b0, 1'b0);
    ifc.start = 1'b1;
    apply(0, 8'h00, 16'h0000, 1'b0);
    for (int k = 0; k < 256; k++) strobe(k, 8'(k) ^ 8'h5A);
    chk_all("resweep", 8'h00, 4'h2, 4'hD, 9'd256, 1'b1, 1'b0);

    // asynchronous reset between edges, with err set beforehand
    restart();
    for (int k = 0; k < 50; k++) strobe(k, 8'(k) ^ 8'h5A);
    apply(50, 8'h00, 16'h0003, 1'b1);
    chk("async_pre_err", 32'(ifc.err), 32'd1);
    chk("async_pre_cnt", 32'(ifc.CandCount), 32'd50);
    #2;
    rst = 1'b1;
    #1;
    chk_all("async", 8'hFF, 4'h0, 4'h0, 9'd0, 1'b0, 1'b0);
    #1;
    rst = 1'b0;
    strobe(51, 8'h00);
    chk("post_reset_idle_cnt", 32'(ifc.CandCount), 32'd0);
    chk("post_reset_idle_best", 32'(ifc.BestDist), 32'hFF);

    // CompStart low gates valid one-hot strobes
    for (int k = 0; k < 20; k++) apply(k, 8'h00, 16'h0001 << (k % 16), 1'b0);
    chk("cs_low_cnt", 32'(ifc.CandCount), 32'd0);
    chk("cs_low_best", 32'(ifc.BestDist), 32'hFF);

    // all-ones distances never replace the initial best but are counted
    restart();
    for (int k = 0; k < 256; k++) strobe(k, 8'hFF);
    chk_all("all_ones", 8'hFF, 4'h0, 4'h0, 9'd256, 1'b1, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
